// File: rtl/coffee_pkg.sv
// Shared types for the vending-machine brewing unit and its coin controller.
package coffee_pkg;

  localparam int unsigned CLK_HZ = 4_000_000;

  typedef enum logic [2:0] {
    IDLE,
    DROP,
    PREHEAT,
    BREW,
    READY,
    WAIT_TAKE,
    TAKEN,
    FAULT
  } brew_state_t;

  typedef struct packed {
    logic cup_drop;
    logic heater_on;
    logic pump_on;
    logic coffee_ready;
    logic cup_out;
    logic busy;
    logic fault;
  } brew_out_t;

endpackage

// File: rtl/coffee_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV clk4m cycles, restartable via clr.
module coffee_tick_gen #(
  parameter int unsigned TICK_DIV = 4000
) (
  input  logic clk4m,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk4m) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/coffee_brewer.sv
// Brewing-unit controller: cup drop, optional preheat, brew, hand-over.
// Preheat phase is built only when COFFEE_BREWER_PREHEAT_EN is defined.
module coffee_brewer
  import coffee_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 4000,
  parameter int unsigned BREW_TICKS    = 16,
  parameter int unsigned PREHEAT_TICKS = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk4m,
  input  logic rst_n,
  input  logic prepare_coffee,
  input  logic water_low,
  input  logic cup_present,
  output logic cup_drop,
  output logic heater_on,
  output logic pump_on,
  output logic coffee_ready,
  output logic cup_out,
  output logic busy,
  output logic fault
);

  brew_state_t      state, next_state;
  brew_out_t        out_d, out_q;
  logic             prep_q, start, clr, tick, phase_done;
  logic [CNT_W-1:0] tick_cnt, tick_target;

  assign start = prepare_coffee & ~prep_q;
  // Any state change restarts both the prescaler and the tick count.
  assign clr   = (next_state != state);

  coffee_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk4m (clk4m),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk4m) begin
    if (!rst_n) begin
      prep_q <= 1'b0;
    end else begin
      prep_q <= prepare_coffee;
    end
  end

  always_ff @(posedge clk4m) begin
    if (!rst_n || clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    tick_target = CNT_W'(BREW_TICKS - 1);
    if (state == PREHEAT) begin
      tick_target = CNT_W'(PREHEAT_TICKS - 1);
    end
    phase_done = tick && (tick_cnt == tick_target);
  end

  always_ff @(posedge clk4m) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = water_low ? FAULT : DROP;
        end
      end
      DROP: begin
`ifdef COFFEE_BREWER_PREHEAT_EN
        next_state = PREHEAT;
`else
        next_state = BREW;
`endif
      end
      PREHEAT: begin
        if (water_low) begin
          next_state = FAULT;
        end else if (phase_done) begin
          next_state = BREW;
        end
      end
      BREW: begin
        if (water_low) begin
          next_state = FAULT;
        end else if (phase_done) begin
          next_state = READY;
        end
      end
      READY:     next_state = WAIT_TAKE;
      WAIT_TAKE: begin
        if (!cup_present) begin
          next_state = TAKEN;
        end
      end
      TAKEN:     next_state = IDLE;
      FAULT: begin
        if (!water_low && !prepare_coffee) begin
          next_state = IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  // Decoded from next_state so the registered outputs line up with the state.
  always_comb begin
    out_d              = '0;
    out_d.cup_drop     = (next_state == DROP);
    out_d.pump_on      = (next_state == BREW);
    out_d.coffee_ready = (next_state == READY);
    out_d.cup_out      = (next_state == TAKEN);
    out_d.busy         = (next_state != IDLE);
    out_d.fault        = (next_state == FAULT);
`ifdef COFFEE_BREWER_PREHEAT_EN
    out_d.heater_on    = (next_state == PREHEAT) || (next_state == BREW);
`endif
  end

  always_ff @(posedge clk4m) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign cup_drop     = out_q.cup_drop;
  assign heater_on    = out_q.heater_on;
  assign pump_on      = out_q.pump_on;
  assign coffee_ready = out_q.coffee_ready;
  assign cup_out      = out_q.cup_out;
  assign busy         = out_q.busy;
  assign fault        = out_q.fault;

endmodule

// File: tb/tb_coffee_brewer.sv
// Self-checking bench for coffee_brewer: vector table, corner-case sequences, random run vs timeline model.
module tb_coffee_brewer;

  localparam int unsigned TD = 4;
  localparam int unsigned BT = 3;
  localparam int unsigned PT = 2;
  localparam int unsigned BD = BT * TD;
`ifdef COFFEE_BREWER_PREHEAT_EN
  localparam bit          PRE = 1'b1;
  localparam int unsigned P   = PT * TD;
`else
  localparam bit          PRE = 1'b0;
  localparam int unsigned P   = 0;
`endif

  logic clk4m = 1'b0;
  logic rst_n = 1'b0;
  logic prepare_coffee = 1'b0;
  logic water_low = 1'b0;
  logic cup_present = 1'b1;
  logic cup_drop, heater_on, pump_on, coffee_ready, cup_out, busy, fault;

  always #125 clk4m = ~clk4m;

  coffee_brewer #(
    .TICK_DIV      (TD),
    .BREW_TICKS    (BT),
    .PREHEAT_TICKS (PT),
    .CNT_W         (8)
  ) dut (
    .clk4m          (clk4m),
    .rst_n          (rst_n),
    .prepare_coffee (prepare_coffee),
    .water_low      (water_low),
    .cup_present    (cup_present),
    .cup_drop       (cup_drop),
    .heater_on      (heater_on),
    .pump_on        (pump_on),
    .coffee_ready   (coffee_ready),
    .cup_out        (cup_out),
    .busy           (busy),
    .fault          (fault)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int c_drop, c_heat, c_pump, c_ready, c_out, c_busy;
  logic [6:0] got;

  // Model: a job is a timeline measured in cycles since the request was accepted.
  typedef enum {M_IDLE, M_JOB, M_WAIT, M_GONE, M_DRY} m_t;
  m_t          m_st   = M_IDLE;
  int unsigned m_n    = 0;
  logic        m_prev = 1'b0;

  function automatic logic [6:0] model_out();
    logic [6:0] e;
    e = '0;
    case (m_st)
      M_JOB: begin
        e[6] = (m_n == 1);
        e[5] = PRE && (m_n >= 2) && (m_n <= 1 + P + BD);
        e[4] = (m_n >= 2 + P) && (m_n <= 1 + P + BD);
        e[3] = (m_n == 2 + P + BD);
        e[1] = 1'b1;
      end
      M_WAIT: e[1] = 1'b1;
      M_GONE: begin e[2] = 1'b1; e[1] = 1'b1; end
      M_DRY:  begin e[1] = 1'b1; e[0] = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic model_edge();
    logic s;
    if (!rst_n) begin
      m_st   = M_IDLE;
      m_prev = 1'b0;
    end else begin
      s      = prepare_coffee && !m_prev;
      m_prev = prepare_coffee;
      case (m_st)
        M_IDLE: if (s) begin
          if (water_low) m_st = M_DRY;
          else begin m_st = M_JOB; m_n = 1; end
        end
        M_JOB: begin
          if (m_n >= 2 && m_n <= 1 + P + BD && water_low) m_st = M_DRY;
          else if (m_n == 2 + P + BD) m_st = M_WAIT;
          else m_n++;
        end
        M_WAIT: if (!cup_present) m_st = M_GONE;
        M_GONE: m_st = M_IDLE;
        M_DRY:  if (!water_low && !prepare_coffee) m_st = M_IDLE;
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [6:0] g, input logic [6:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (drop,heat,pump,ready,out,busy,fault) at %0t", name, g, e, $time);
    end
  endtask

  task automatic check_int(input string name, input int g, input int e);
    n_chk++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, g, e, $time);
    end
  endtask

  task automatic clr_cnt();
    c_drop = 0; c_heat = 0; c_pump = 0; c_ready = 0; c_out = 0; c_busy = 0;
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk4m);
    model_edge();
    @(negedge clk4m);
    got = {cup_drop, heater_on, pump_on, coffee_ready, cup_out, busy, fault};
    check("model", got, model_out());
    c_drop  += int'(cup_drop);
    c_heat  += int'(heater_on);
    c_pump  += int'(pump_on);
    c_ready += int'(coffee_ready);
    c_out   += int'(cup_out);
    c_busy  += int'(busy);
  endtask

  task automatic brew(input bit toggle, input int unsigned hold, input string tag);
    int unsigned guard;
    clr_cnt();
    water_low = 1'b0; cup_present = 1'b1; prepare_coffee = 1'b0;
    step();
    prepare_coffee = 1'b1;
    step();
    guard = 0;
    while (c_ready == 0 && guard < 200) begin
      if (toggle) prepare_coffee = ~prepare_coffee;
      step();
      guard++;
    end
    check_int({tag, " ready"}, c_ready, 1);
    c_busy = 0;
    for (int unsigned i = 0; i < hold; i++) begin
      if (toggle) prepare_coffee = ~prepare_coffee;
      step();
    end
    check_int({tag, " busy while waiting"}, c_busy, int'(hold));
    check_int({tag, " no early cup_out"}, c_out, 0);
    cup_present = 1'b0;
    step();
    check_int({tag, " cup_out"}, int'(cup_out), 1);
    step();
    check_int({tag, " idle after taken"}, int'(busy), 0);
    check_int({tag, " cup_drop count"}, c_drop, 1);
    check_int({tag, " pump cycles"}, c_pump, int'(BD));
    check_int({tag, " heater cycles"}, c_heat, PRE ? int'(P + BD) : 0);
    check_int({tag, " cup_out count"}, c_out, 1);
    cup_present = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       prep;
    logic       wl;
    logic       cup;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int unsigned guard;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0000000};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0000011};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b0000011};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0000011};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b1000010};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0000000};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b1000010};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000};

    clr_cnt();
    for (int i = 0; i < 10; i++) begin
      rst_n = tbl[i].rst_n; prepare_coffee = tbl[i].prep;
      water_low = tbl[i].wl; cup_present = tbl[i].cup;
      step();
      check($sformatf("table[%0d]", i), got, tbl[i].exp);
    end
    rst_n = 1'b1;

    // Normal brew, then slow customer with a 100-cycle hold.
    brew(1'b0, 3, "normal");
    brew(1'b0, 100, "slow customer");

    // Request toggled during brew and wait must not start another cup.
    brew(1'b1, 6, "toggle");

    // Request held high through hand-over must not re-trigger.
    brew(1'b0, 2, "held");
    prepare_coffee = 1'b1;
    clr_cnt();
    for (int i = 0; i < 10; i++) step();
    check_int("held high no drop", c_drop, 0);
    check_int("held high idle", c_busy, 0);

    // Reset in the middle of brewing.
    clr_cnt();
    prepare_coffee = 1'b0; step();
    prepare_coffee = 1'b1; step();
    guard = 0;
    while (c_pump < 5 && guard < 100) begin step(); guard++; end
    check_int("reach mid-brew", c_pump, 5);
    rst_n = 1'b0; prepare_coffee = 1'b0;
    step();
    check("reset outputs", got, 7'b0000000);
    step();
    check("reset held", got, 7'b0000000);
    rst_n = 1'b1;
    step();
    check_int("idle after reset", int'(busy), 0);
    brew(1'b0, 2, "after reset");

    // Dry tank at request.
    water_low = 1'b1; prepare_coffee = 1'b0; step();
    prepare_coffee = 1'b1; step();
    check("dry request", got, 7'b0000011);
    prepare_coffee = 1'b0; water_low = 1'b0; step();
    check_int("dry request clears", int'(busy), 0);

    // Tank runs dry at the fifth pump cycle.
    clr_cnt();
    prepare_coffee = 1'b1; step();
    guard = 0;
    while (c_pump < 5 && guard < 100) begin step(); guard++; end
    check_int("reach pump cycle 5", c_pump, 5);
    water_low = 1'b1; step();
    check("dry mid-brew", got, 7'b0000011);
    for (int i = 0; i < 5; i++) step();
    check_int("dry no ready", c_ready, 0);
    check_int("dry no cup_out", c_out, 0);
    water_low = 1'b0; prepare_coffee = 1'b0; step();
    check_int("dry clears", int'(busy), 0);

    // Random traffic checked every cycle against the timeline model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 5) == 0)  prepare_coffee = ~prepare_coffee;
      if ($urandom_range(0, 39) == 0) water_low = ~water_low;
      if ($urandom_range(0, 9) == 0)  cup_present = ~cup_present;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
